// File: rtl/square_fp_pkg.sv
// Shared fixed-point parameters and types for the square/sqrt datapath blocks.
package square_fp_pkg;

  localparam int unsigned FP_WIDTH = 32;
  localparam int unsigned FP_FBITS = 10;
  localparam int unsigned FP_ITER  = FP_WIDTH;
  localparam int unsigned FP_CNT_W = $clog2(FP_WIDTH) + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sq_state_e;

  // Counter width wide enough to hold ITER without wrapping for any width.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/square_fp_if.sv
// Start/operand and result bundle between a requester and the squarer.
interface square_fp_if
  import square_fp_pkg::*;
#(
  parameter int unsigned WIDTH = FP_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] val;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] sq;
  logic             ovf;
  logic             inexact;

  modport master (output start, val, input busy, valid, sq, ovf, inexact);
  modport slave  (input start, val, output busy, valid, sq, ovf, inexact);
endinterface

// File: rtl/square_fp_step.sv
// One shift-add step: conditionally add the aligned multiplicand to the accumulator.
module square_fp_step #(
  parameter int unsigned PW = 64
) (
  input  logic [PW-1:0] acc,
  input  logic [PW-1:0] addend,
  input  logic          en,
  output logic [PW-1:0] acc_next
);
  always_comb begin
    acc_next = acc;
    if (en) acc_next = acc + addend;
  end
endmodule

// File: rtl/square_fp.sv
// Iterative unsigned fixed-point squarer: one multiplier bit per cycle, LSB first.
module square_fp
  import square_fp_pkg::*;
#(
  parameter int unsigned WIDTH = FP_WIDTH,
  parameter int unsigned FBITS = FP_FBITS
) (
  input  logic       clk,
  input  logic       rst,
  square_fp_if.slave bus
);

  localparam int unsigned ITER  = WIDTH;
  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam int unsigned PW    = 2 * WIDTH;

  localparam logic [PW-1:0]    LOW_MASK = (PW'(1) << FBITS) - PW'(1);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(ITER - 1);

  sq_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mult;
  logic [PW-1:0]    acc_next_c;

  logic             busy_q;
  logic             valid_q;
  logic [WIDTH-1:0] sq_q;
  logic             ovf_q;
  logic             inexact_q;

  square_fp_step #(.PW(PW)) u_step (
    .acc      (acc),
    .addend   (mcand),
    .en       (mult[0]),
    .acc_next (acc_next_c)
  );

  // Start (or restart) takes priority over an in-flight iteration; reset over both.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mult      <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      sq_q      <= '0;
      ovf_q     <= 1'b0;
      inexact_q <= 1'b0;
    end else if (bus.start) begin
      state   <= ST_RUN;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= PW'(bus.val);
      mult    <= bus.val;
      busy_q  <= 1'b1;
      valid_q <= 1'b0;
    end else if (state == ST_RUN) begin
      acc   <= acc_next_c;
      mcand <= mcand << 1;
      mult  <= mult >> 1;
      cnt   <= cnt + CNT_W'(1);
      if (cnt == LAST) begin
        state     <= ST_IDLE;
        busy_q    <= 1'b0;
        valid_q   <= 1'b1;
        sq_q      <= WIDTH'(acc_next_c >> FBITS);
        ovf_q     <= (acc_next_c >> (FBITS + WIDTH)) != '0;
        inexact_q <= (acc_next_c & LOW_MASK) != '0;
      end
    end
  end

  assign bus.busy    = busy_q;
  assign bus.valid   = valid_q;
  assign bus.sq      = sq_q;
  assign bus.ovf     = ovf_q;
  assign bus.inexact = inexact_q;

endmodule
